// File: rtl/pong_matrix_driver.sv
// ============================================================================
// Module   : pong_matrix_driver
// Purpose  : Renders the pong playfield onto a 64x32 1/16-scan HUB75 panel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pong_matrix_driver #(
    parameter int ON_CYCLES     = 256,
    parameter int PADDLE_HEIGHT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] leftPaddleY,
    input  logic [5:0] rightPaddleY,
    input  logic [5:0] xBallPosition,
    input  logic [4:0] yBallPosition,
    input  logic [3:0] leftScore,
    input  logic [3:0] rightScore,
    output logic       matClk,
    output logic       matLatch,
    output logic       matOE_n,
    output logic [3:0] matAddr,
    output logic [2:0] matRGB1,
    output logic [2:0] matRGB2,
    output logic       frameStart
);

    typedef enum logic [1:0] {
        ST_SHIFT   = 2'd0,
        ST_BLANK   = 2'd1,
        ST_LATCH   = 2'd2,
        ST_DISPLAY = 2'd3
    } state_t;

    // One counter serves both the 128-cycle shift and the display dwell.
    localparam int               C_CNT_W      = (ON_CYCLES > 128) ? $clog2(ON_CYCLES) : 7;
    localparam logic [C_CNT_W-1:0] C_SHIFT_LAST = C_CNT_W'(127);
    localparam logic [C_CNT_W-1:0] C_DISP_LAST  = C_CNT_W'(ON_CYCLES - 1);
    localparam logic [6:0]       C_PH         = 7'(PADDLE_HEIGHT);

    state_t               state_q, state_d;
    logic [3:0]           row_q, row_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]           lp_q, lp_d, rp_q, rp_d, bx_q, bx_d;
    logic [4:0]           by_q, by_d;
    logic [3:0]           ls_q, ls_d, rs_q, rs_d;
    logic                 mat_clk_q, mat_clk_d;
    logic                 mat_latch_q, mat_latch_d;
    logic                 mat_oe_n_q, mat_oe_n_d;
    logic [3:0]           mat_addr_q, mat_addr_d;
    logic [2:0]           mat_rgb1_q, mat_rgb1_d;
    logic [2:0]           mat_rgb2_q, mat_rgb2_d;
    logic                 frame_start_q, frame_start_d;

    logic                 w_sample;
    logic [5:0]           w_lp, w_rp, w_bx, w_col;
    logic [4:0]           w_by;
    logic [3:0]           w_ls, w_rs;

    function automatic logic in_paddle(input logic [5:0] top, input logic [4:0] row);
        logic [6:0] top7;
        logic [6:0] row7;
        top7 = {1'b0, top};
        row7 = {2'b00, row};
        return (row7 <= top7) && ((top7 - row7) < C_PH);
    endfunction

    function automatic logic [2:0] pixel(
        input logic [5:0] col,
        input logic [4:0] row,
        input logic [5:0] bx,
        input logic [4:0] by,
        input logic [5:0] lp,
        input logic [5:0] rp,
        input logic [3:0] ls,
        input logic [3:0] rs
    );
        logic [6:0] col7;
        logic [6:0] ls7;
        logic [6:0] rs7;
        logic       r;
        logic       g;
        logic       b;
        col7 = {1'b0, col};
        ls7  = {3'b000, ls};
        rs7  = {3'b000, rs};
        r    = (col == bx) && (row == by);
        g    = ((col == 6'd0)  && in_paddle(lp, row)) ||
               ((col == 6'd63) && in_paddle(rp, row));
        b    = (row == 5'd0) &&
               (((col7 >= 7'd16) && (col7 <= 7'd15 + ls7)) ||
                ((col7 >= 7'd48 - rs7) && (col7 <= 7'd47)));
        return {r, g, b};
    endfunction

    // The frame's first pixel is drawn from the live inputs on the same edge they are captured.
    assign w_sample = (state_q == ST_SHIFT) && (row_q == 4'd0) && (cnt_q == '0);
    assign w_lp     = w_sample ? leftPaddleY   : lp_q;
    assign w_rp     = w_sample ? rightPaddleY  : rp_q;
    assign w_bx     = w_sample ? xBallPosition : bx_q;
    assign w_by     = w_sample ? yBallPosition : by_q;
    assign w_ls     = w_sample ? leftScore     : ls_q;
    assign w_rs     = w_sample ? rightScore    : rs_q;
    assign w_col    = cnt_q[6:1];

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        cnt_d         = cnt_q;
        lp_d          = w_lp;
        rp_d          = w_rp;
        bx_d          = w_bx;
        by_d          = w_by;
        ls_d          = w_ls;
        rs_d          = w_rs;
        mat_clk_d     = 1'b0;
        mat_latch_d   = 1'b0;
        mat_oe_n_d    = 1'b1;
        mat_addr_d    = mat_addr_q;
        mat_rgb1_d    = 3'b000;
        mat_rgb2_d    = 3'b000;
        frame_start_d = 1'b0;

        case (state_q)
            ST_SHIFT: begin
                mat_clk_d     = cnt_q[0];
                mat_rgb1_d    = pixel(w_col, {1'b0, row_q}, w_bx, w_by, w_lp, w_rp, w_ls, w_rs);
                mat_rgb2_d    = pixel(w_col, {1'b1, row_q}, w_bx, w_by, w_lp, w_rp, w_ls, w_rs);
                frame_start_d = w_sample;
                if (cnt_q == C_SHIFT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_BLANK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BLANK: begin
                mat_addr_d = row_q;
                state_d    = ST_LATCH;
            end
            ST_LATCH: begin
                mat_latch_d = 1'b1;
                state_d     = ST_DISPLAY;
            end
            default: begin
                mat_oe_n_d = 1'b0;
                if (cnt_q == C_DISP_LAST) begin
                    cnt_d   = '0;
                    row_d   = row_q + 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_SHIFT;
            row_q         <= 4'd0;
            cnt_q         <= '0;
            lp_q          <= 6'd0;
            rp_q          <= 6'd0;
            bx_q          <= 6'd0;
            by_q          <= 5'd0;
            ls_q          <= 4'd0;
            rs_q          <= 4'd0;
            mat_clk_q     <= 1'b0;
            mat_latch_q   <= 1'b0;
            mat_oe_n_q    <= 1'b1;
            mat_addr_q    <= 4'd0;
            mat_rgb1_q    <= 3'b000;
            mat_rgb2_q    <= 3'b000;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            cnt_q         <= cnt_d;
            lp_q          <= lp_d;
            rp_q          <= rp_d;
            bx_q          <= bx_d;
            by_q          <= by_d;
            ls_q          <= ls_d;
            rs_q          <= rs_d;
            mat_clk_q     <= mat_clk_d;
            mat_latch_q   <= mat_latch_d;
            mat_oe_n_q    <= mat_oe_n_d;
            mat_addr_q    <= mat_addr_d;
            mat_rgb1_q    <= mat_rgb1_d;
            mat_rgb2_q    <= mat_rgb2_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign matClk     = mat_clk_q;
    assign matLatch   = mat_latch_q;
    assign matOE_n    = mat_oe_n_q;
    assign matAddr    = mat_addr_q;
    assign matRGB1    = mat_rgb1_q;
    assign matRGB2    = mat_rgb2_q;
    assign frameStart = frame_start_q;

endmodule

`default_nettype wire
